// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared encodings for the data-memory arbiter
package dmem_arbiter_pkg;

    // Access size codes, identical to the MEM-stage BYTE/HALF/WORD codes
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // A halfword must sit on an even address, a word on a multiple of four
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SIZE_HALF) && addr_lo[0]) ||
               ((size == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// rtl/dmem_arb_prio.sv - data-first grant decision with fetch anti-starvation counter
module dmem_arb_prio #(
    parameter int DATA_BURST_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic grant_d,
    output logic grant_if
);

    logic [3:0] burst_cnt;

    // Data wins unless fetch has waited through a full burst of data grants
    always_comb begin
        grant_d  = arb_en && d_req && (!if_req || (burst_cnt < 4'(DATA_BURST_MAX)));
        grant_if = arb_en && if_req && !grant_d;
    end

    // Count data grants taken while fetch is pending; any other grant clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= 4'd0;
        end else if (grant_d) begin
            if (if_req) begin
                burst_cnt <= (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
            end else begin
                burst_cnt <= 4'd0;
            end
        end else if (grant_if) begin
            burst_cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data-memory port between fetch and the MEM stage
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic        mem_mreq,
    output logic        mem_write,
    output logic [1:0]  mem_access_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_ack
);

    state_t      state;
    state_t      next_state;
    owner_t      owner;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_err;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        grant_d;
    logic        grant_if;
    logic        d_misaligned;

    assign d_misaligned = is_misaligned(d_size, d_addr[1:0]);

    dmem_arb_prio #(
        .DATA_BURST_MAX(DATA_BURST_MAX)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .arb_en   (state == ST_IDLE),
        .if_req   (if_req),
        .d_req    (d_req),
        .grant_d  (grant_d),
        .grant_if (grant_if)
    );

    // Address/size come straight from the latched transaction so they hold between cycles
    assign mem_addr        = lat_addr;
    assign mem_access_size = lat_size;
    assign if_rdata        = if_rdata_q;
    assign d_rdata         = d_rdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and memory/response strobes
    always_comb begin
        next_state  = state;
        mem_mreq    = 1'b0;
        mem_write   = 1'b0;
        mem_wr_data = 32'd0;
        if_done     = 1'b0;
        d_done      = 1'b0;
        d_err       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_d) begin
                    next_state = d_misaligned ? ST_RESP : ST_BUSY;
                end else if (grant_if) begin
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                mem_mreq    = 1'b1;
                mem_write   = lat_write;
                mem_wr_data = lat_write ? lat_wdata : 32'd0;
                if (mem_ack) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
                if_done    = (owner == OWN_IF);
                d_done     = (owner == OWN_D);
                d_err      = (owner == OWN_D) && lat_err;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the granted transaction and capture read data on acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_IF;
            lat_write  <= 1'b0;
            lat_size   <= 2'b00;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_err    <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            if (grant_d) begin
                owner     <= OWN_D;
                lat_write <= d_write;
                lat_size  <= d_size;
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
                lat_err   <= d_misaligned;
            end else if (grant_if) begin
                owner     <= OWN_IF;
                lat_write <= 1'b0;
                lat_size  <= SIZE_WORD;
                lat_addr  <= if_addr;
                lat_wdata <= 32'd0;
                lat_err   <= 1'b0;
            end
            if ((state == ST_BUSY) && mem_ack) begin
                if (owner == OWN_IF) begin
                    if_rdata_q <= mem_rd_data;
                end else begin
                    d_rdata_q <= lat_write ? 32'd0 : mem_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized bench with a transaction-timeline model for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_write;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic        mem_mreq;
    logic        mem_write;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_ack;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_BURST_MAX(BURST)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .mem_mreq(mem_mreq), .mem_write(mem_write), .mem_access_size(mem_access_size),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_ack(mem_ack)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [1:0]  wait_n;
    } spec_t;

    typedef struct packed {
        logic        mreq;
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rd;
        logic        if_done;
        logic        d_done;
        logic        d_err;
        logic [31:0] rdata;
    } frame_t;

    spec_t  d_q[$];
    spec_t  i_q[$];
    frame_t q[$];
    frame_t cur;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int cnt = 0;
    int d_gap = 0;
    int i_gap = 0;
    bit random_gaps = 0;
    int grant_cyc = 0;

    int          obs_mreq_cycles;
    int          obs_wr_match;
    int          obs_done_cyc;
    int          obs_d_done_n;
    logic [31:0] obs_if_rdata;
    logic [31:0] obs_d_rdata;
    logic        obs_d_err;
    logic [1:0]  obs_size;
    logic [9:0]  done_log;

    initial begin
        #2000000;
        $display("FAIL watchdog cycle %0d: simulation did not finish, required finish", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got 0x%08h required 0x%08h", name, cyc, act, want);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic want);
        chk(name, {31'd0, act}, {31'd0, want});
    endtask

    function automatic spec_t mk(input logic [31:0] addr, input logic [1:0] size, input logic write,
                                 input logic [31:0] wdata, input logic [31:0] rd, input logic [1:0] wait_n);
        spec_t s;
        s.addr = addr; s.size = size; s.write = write;
        s.wdata = wdata; s.rd = rd; s.wait_n = wait_n;
        return s;
    endfunction

    // An access is misaligned when its address is not a multiple of its byte count
    function automatic bit bad_align(input spec_t s);
        int bytes;
        bytes = 1 << s.size;
        return (s.addr % bytes) != 0;
    endfunction

    // Expand one arbitration decision into the per-cycle outputs it must produce
    task automatic arbitrate();
        frame_t f;
        spec_t  s;
        bit     to_d;
        f = '0;
        if (d_req && (!if_req || cnt < BURST)) begin
            s = d_q[0];
            to_d = 1;
            cnt = if_req ? ((cnt < 15) ? cnt + 1 : cnt) : 0;
        end else if (if_req) begin
            s = i_q[0];
            s.size = SIZE_WORD;
            s.write = 1'b0;
            to_d = 0;
            cnt = 0;
        end else begin
            q.push_back(f);
            return;
        end
        grant_cyc = cyc;
        if (to_d && bad_align(s)) begin
            f.d_done = 1'b1;
            f.d_err = 1'b1;
            q.push_back(f);
        end else begin
            for (int k = 0; k <= int'(s.wait_n); k++) begin
                f = '0;
                f.mreq = 1'b1;
                f.write = s.write;
                f.size = s.size;
                f.addr = s.addr;
                f.wdata = s.write ? s.wdata : 32'd0;
                f.ack = (k == int'(s.wait_n));
                f.rd = s.rd;
                q.push_back(f);
            end
            f = '0;
            f.if_done = !to_d;
            f.d_done = to_d;
            f.rdata = (to_d && s.write) ? 32'd0 : s.rd;
            q.push_back(f);
        end
        f = '0;
        q.push_back(f);
    endtask

    task automatic drive_inputs();
        if (d_gap > 0) d_gap--;
        if (i_gap > 0) i_gap--;
        d_req = (d_q.size() > 0) && (d_gap == 0);
        if (d_req) begin
            d_write = d_q[0].write;
            d_size = d_q[0].size;
            d_addr = d_q[0].addr;
            d_wdata = d_q[0].wdata;
        end
        if_req = (i_q.size() > 0) && (i_gap == 0);
        if (if_req) if_addr = i_q[0].addr;
    endtask

    task automatic compare();
        chk1("mem_mreq", mem_mreq, cur.mreq);
        chk1("mem_write", mem_write, cur.write);
        chk("mem_wr_data", mem_wr_data, cur.wdata);
        chk1("if_done", if_done, cur.if_done);
        chk1("d_done", d_done, cur.d_done);
        chk1("d_err", d_err, cur.d_err);
        if (cur.mreq) begin
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_access_size", {30'd0, mem_access_size}, {30'd0, cur.size});
        end
        if (cur.if_done) chk("if_rdata", if_rdata, cur.rdata);
        if (cur.d_done && !cur.d_err) chk("d_rdata", d_rdata, cur.rdata);
        if (mem_mreq) begin
            obs_mreq_cycles++;
            obs_size = mem_access_size;
            if (mem_write && mem_wr_data == 32'h12345678) obs_wr_match++;
        end
        if (if_done) begin
            obs_done_cyc = cyc;
            obs_if_rdata = if_rdata;
            done_log = {done_log[8:0], 1'b0};
        end
        if (d_done) begin
            obs_done_cyc = cyc;
            obs_d_rdata = d_rdata;
            obs_d_err = d_err;
            obs_d_done_n++;
            done_log = {done_log[8:0], 1'b1};
        end
    endtask

    task automatic cycle();
        drive_inputs();
        if (q.size() == 0) arbitrate();
        @(posedge clk);
        #1;
        cyc++;
        cur = q.pop_front();
        compare();
        if (cur.d_done) begin
            d_q.delete(0);
            if (random_gaps) d_gap = $urandom_range(0, 3);
        end
        if (cur.if_done) begin
            i_q.delete(0);
            if (random_gaps) i_gap = $urandom_range(0, 3);
        end
        mem_ack = cur.ack;
        mem_rd_data = cur.ack ? cur.rd : $urandom;
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((d_q.size() > 0 || i_q.size() > 0 || q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout cycle %0d: got %0d cycles required fewer than %0d", name, cyc, n, budget);
        end
    endtask

    task automatic obs_clear();
        obs_mreq_cycles = 0;
        obs_wr_match = 0;
        obs_done_cyc = 0;
        obs_d_done_n = 0;
        obs_if_rdata = 32'd0;
        obs_d_rdata = 32'd0;
        obs_d_err = 1'b0;
        obs_size = 2'b11;
        done_log = 10'd0;
    endtask

    task automatic reset_model();
        q.delete();
        cnt = 0;
        cur = '0;
        d_gap = 0;
        i_gap = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_mem_mreq"}, mem_mreq, 1'b0);
        chk1({tag, "_mem_write"}, mem_write, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_size"}, {30'd0, mem_access_size}, 32'd0);
        chk({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
        chk1({tag, "_if_done"}, if_done, 1'b0);
        chk1({tag, "_d_done"}, d_done, 1'b0);
        chk1({tag, "_d_err"}, d_err, 1'b0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_write = 1'b0; d_size = 2'b00; d_addr = 32'd0; d_wdata = 32'd0;
        mem_rd_data = 32'd0; mem_ack = 1'b0;
        obs_clear();
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Fetch alone
        obs_clear();
        i_q.push_back(mk(32'h100, SIZE_WORD, 1'b0, 32'd0, 32'hDEADBEEF, 2'd0));
        run_until_idle(50, "fetch");
        chk("fetch_if_rdata", obs_if_rdata, 32'hDEADBEEF);
        chk("fetch_latency", obs_done_cyc - grant_cyc, 32'd2);
        chk("fetch_mreq_cycles", obs_mreq_cycles, 32'd1);

        // Store with two wait states
        obs_clear();
        d_q.push_back(mk(32'h200, SIZE_WORD, 1'b1, 32'h12345678, 32'hA5A5A5A5, 2'd2));
        run_until_idle(50, "store");
        chk("store_write_cycles", obs_wr_match, 32'd3);
        chk("store_mreq_cycles", obs_mreq_cycles, 32'd3);
        chk1("store_d_err", obs_d_err, 1'b0);
        chk("store_latency", obs_done_cyc - grant_cyc, 32'd4);

        // Misaligned half load then misaligned word store
        obs_clear();
        d_q.push_back(mk(32'h201, SIZE_HALF, 1'b0, 32'd0, 32'h11111111, 2'd0));
        d_q.push_back(mk(32'h202, SIZE_WORD, 1'b1, 32'hCAFEF00D, 32'h22222222, 2'd0));
        run_until_idle(50, "misaligned");
        chk("misaligned_mreq_cycles", obs_mreq_cycles, 32'd0);
        chk("misaligned_done_count", obs_d_done_n, 32'd2);
        chk1("misaligned_d_err", obs_d_err, 1'b1);
        chk("misaligned_latency", obs_done_cyc - grant_cyc, 32'd1);

        // Byte load returns raw data
        obs_clear();
        d_q.push_back(mk(32'h203, SIZE_BYTE, 1'b0, 32'd0, 32'h000000F0, 2'd1));
        run_until_idle(50, "byte");
        chk("byte_d_rdata", obs_d_rdata, 32'h000000F0);
        chk("byte_size", {30'd0, obs_size}, {30'd0, SIZE_BYTE});

        // Collision: both requesters continuously busy
        obs_clear();
        for (int i = 0; i < 8; i++)
            d_q.push_back(mk(32'h400 + 32'(i * 4), SIZE_WORD, 1'b0, 32'd0, 32'h5000 + 32'(i), 2'd0));
        for (int i = 0; i < 2; i++)
            i_q.push_back(mk(32'h800 + 32'(i * 4), SIZE_WORD, 1'b0, 32'd0, 32'h9000 + 32'(i), 2'd0));
        run_until_idle(200, "collision");
        chk("collision_order", {22'd0, done_log}, {22'd0, 10'b1111011110});

        // Reset while a load waits, with an acknowledge in the reset cycle
        obs_clear();
        d_q.push_back(mk(32'h300, SIZE_WORD, 1'b0, 32'd0, 32'h77777777, 2'd3));
        cycle();
        cycle();
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rd_data = 32'h77777777;
        @(posedge clk);
        #1;
        cyc++;
        chk_all_zero("rst_busy");
        rst = 1'b0;
        mem_ack = 1'b0;
        d_q.delete();
        reset_model();
        repeat (4) cycle();
        chk("rst_no_d_done", obs_d_done_n, 32'd0);
        i_q.push_back(mk(32'h180, SIZE_WORD, 1'b0, 32'd0, 32'h0BADF00D, 2'd1));
        run_until_idle(50, "post_reset_fetch");
        chk("post_reset_if_rdata", obs_if_rdata, 32'h0BADF00D);

        // Randomized traffic from both requesters
        random_gaps = 1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
            d_q.push_back(mk(a, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                             $urandom, $urandom, 2'($urandom_range(0, 3))));
        end
        for (int i = 0; i < 120; i++)
            i_q.push_back(mk($urandom & ~32'h3, SIZE_WORD, 1'b0, 32'd0, $urandom,
                             2'($urandom_range(0, 3))));
        run_until_idle(20000, "random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single data-memory port between instruction fetch (IF) and the MEM stage load/store path.
- Registers one transaction at a time and holds the memory request until the memory acknowledges it. Returns read data to the owning requester with a one-cycle done pulse.
- The MEM stage has priority. A starvation counter guarantees fetch progress.
- Misaligned data accesses are rejected without touching memory.

Parameters:
- DATA_BURST_MAX, 4: maximum consecutive data grants while if_req is pending before one fetch grant is forced. Range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held stable until if_done
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word; valid when if_done=1
- if_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request (mreq from MEM stage); held stable until d_done
- d_write  in  1  1=store, 0=load
- d_size  in  2  `BYTE/`HALF/`WORD
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  raw load data; sign/zero extension stays in MEM stage
- d_done  out  1  one-cycle completion pulse for data
- d_err  out  1  misalignment error; qualified by d_done
- mem_mreq  out  1  memory request
- mem_write  out  1  memory write enable
- mem_access_size  out  2  memory access size
- mem_addr  out  32  memory address
- mem_wr_data  out  32  memory write data
- mem_rd_data  in  32  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion; sampled only in BUSY

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; owner, burst counter and all latched fields cleared.
  - Every output is 0.
  - A mem_ack arriving in the reset cycle is ignored.
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, d_req=1 and (if_req=0 or burst_cnt<DATA_BURST_MAX):
  - Grant data and latch d_write, d_size, d_addr, d_wdata.
  - If if_req=1, burst_cnt++ (saturating); otherwise burst_cnt=0.
- IDLE, otherwise with if_req=1:
  - Grant fetch and latch if_addr; size=`WORD, write=0.
  - burst_cnt=0.
- Misalignment check on a data grant:
  - Misaligned means `HALF with addr[0]=1, or `WORD with addr[1:0]!=0.
  - A misaligned grant goes directly to RESP with err flag set. No memory cycle is issued.
- Otherwise a grant goes to BUSY.
- BUSY outputs:
  - mem_mreq=1; mem_addr and mem_access_size come from the latched fields.
  - mem_write = latched write.
  - mem_wr_data = latched wdata when write=1, else 0.
  - Remain in BUSY until mem_ack=1. There is no timeout.
  - On mem_ack: capture mem_rd_data (loads and fetches; stores capture 0), then go to RESP.
- RESP:
  - Assert the owner's done for exactly one cycle, with rdata/err valid.
  - The owner drops or changes its request on the same edge.
  - RESP always goes to IDLE. Requests are not evaluated in RESP.
- Outside BUSY: mem_mreq=0, mem_write=0, mem_wr_data=0.
  - mem_addr and mem_access_size hold their last values.
  - if_rdata and d_rdata hold their last values. Done/err are 0 except in RESP.
- Latency:
  - Request seen in IDLE at cycle N, mem_ack in the first BUSY cycle: done at N+2, next arbitration at N+3.
  - Each additional wait cycle adds 1.
  - Misaligned access: done at N+1.
- Simultaneous d_req and if_req: data wins unless burst_cnt==DATA_BURST_MAX, in which case fetch wins and the counter clears.
- Requests deasserted while BUSY are not observed. The latched transaction completes.
- Changing a request mid-transaction is a protocol violation; behaviour is undefined and needs no checker.
- A misaligned store never asserts mem_write.

Decomposition:
- Shared package/defines:
  - `BYTE/`HALF/`WORD size codes, reused from the existing MEM-stage definitions.
  - State encodings IDLE/BUSY/RESP.
  - Owner encoding OWN_IF/OWN_D.
- One natural sub-module: dmem_arb_prio. It is the combinational grant decision plus the saturating burst counter register.
- The FSM and datapath latches stay in dmem_arbiter.

Test Plan:
- Fetch alone: if_req=1, if_addr=0x100, mem_ack in the first BUSY cycle with rd=0xDEADBEEF. Required response: mem_mreq high one cycle, size=`WORD, write=0; if_done pulses two cycles after the request with if_rdata=0xDEADBEEF.
- Store with two wait states: d_req=1, d_write=1, `WORD, addr=0x200, wdata=0x12345678, mem_ack after three BUSY cycles. Required response: mem_write=1 and wr_data=0x12345678 for all three cycles; d_done with d_err=0.
- Collision and fairness: d_req and if_req held high continuously, DATA_BURST_MAX=4, requests re-raised after each done. Required grant order: D,D,D,D,I,D,D,D,D,I.
- Misaligned access: `HALF at 0x201, then `WORD at 0x202. Required response: mem_mreq never rises; d_done and d_err=1 one cycle after each request.
- Reset mid-BUSY: rst asserted while a load is waiting, with mem_ack in the same cycle. Required response: all outputs 0 next cycle, no d_done, state IDLE; a fresh fetch then completes normally.
- Byte load: `BYTE at 0x203, rd=0x000000F0. Required response: d_rdata=0x000000F0 raw, mem_access_size=`BYTE.
